// File: rtl/aead_bus_seq.sv
// aead_bus_seq: 32-bit register bus front end and command sequencer for a
// ChaCha20-Poly1305 AEAD core.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   cs, we, address, write_data  CPU register bus (word addressed)
//   read_data                    registered read data (2-edge pipeline)
//   core_init/next/done          one-cycle command strobes to the core
//   core_encdec, core_key,
//   core_nonce, core_data_in     operands (word 0 in the MSBs)
//   core_ready/valid/tag_ok,
//   core_data_out, core_tag      core status and results
//   irq                          interrupt (only with AEAD_BUS_IRQ_EN)
//
// Build option: define AEAD_BUS_IRQ_EN to add the IRQ enable register
// (0x0B) and the registered irq output.
module aead_bus_seq #(
    parameter int DATA_WORDS   = 16,
    parameter int CORE_TIMEOUT = 1023
) (
`ifdef AEAD_BUS_IRQ_EN
    output logic                    irq,
`endif
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cs,
    input  logic                    we,
    input  logic [7:0]              address,
    input  logic [31:0]             write_data,
    output logic [31:0]             read_data,
    output logic                    core_init,
    output logic                    core_next,
    output logic                    core_done,
    output logic                    core_encdec,
    output logic [255:0]            core_key,
    output logic [95:0]             core_nonce,
    output logic [DATA_WORDS*32-1:0] core_data_in,
    input  logic                    core_ready,
    input  logic                    core_valid,
    input  logic                    core_tag_ok,
    input  logic [DATA_WORDS*32-1:0] core_data_out,
    input  logic [127:0]            core_tag
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    localparam int          AW       = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam logic [7:0]  DW8      = 8'(DATA_WORDS);
    localparam logic [15:0] TMO_LAST = 16'(CORE_TIMEOUT - 1);

    state_e state_q, state_d;

    logic [31:0] key_q   [8];
    logic [31:0] key_d   [8];
    logic [31:0] nonce_q [3];
    logic [31:0] nonce_d [3];
    logic [31:0] data_q  [DATA_WORDS];
    logic [31:0] data_d  [DATA_WORDS];
    logic [31:0] dout_w  [DATA_WORDS];
    logic [31:0] tag_w   [4];

    logic        encdec_q, encdec_d;
    logic [2:0]  cmd_q, cmd_d;
    logic        go_q, go_d;
    logic        seen_low_q, seen_low_d;
    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic [15:0] blkcnt_q, blkcnt_d;
    logic        rd_q;
    logic [31:0] rdata_q, rdout_q, rmux;
`ifdef AEAD_BUS_IRQ_EN
    logic        irq_en_q, irq_q;
`endif

    logic       wr, rd;
    logic       ctrl_wr, stat_wr, cfg_wr, cnt_wr, key_wr, non_wr, dat_wr;
    logic [7:0] doff;
    logic [AW-1:0] didx;
    logic [2:0] cmd_bits;
    logic       abort, one_hot, multi, accept, locked, drop;
    logic       complete, tmo_hit, busy;
    logic [31:0] status;

    // ---------------- bus decode ----------------
    assign wr       = cs & we;
    assign rd       = cs & ~we;
    assign doff     = address - 8'h30;
    assign didx     = doff[AW-1:0];
    assign ctrl_wr  = wr & (address == 8'h08);
    assign stat_wr  = wr & (address == 8'h09);
    assign cfg_wr   = wr & (address == 8'h0A);
    assign cnt_wr   = wr & (address == 8'h0C);
    assign key_wr   = wr & (address[7:3] == 5'b00010);
    assign non_wr   = wr & (address >= 8'h20) & (address <= 8'h22);
    assign dat_wr   = wr & (address >= 8'h30) & (doff < DW8);

    assign cmd_bits = write_data[2:0];
    assign abort    = ctrl_wr & write_data[3];
    assign one_hot  = $onehot(cmd_bits);
    assign multi    = (cmd_bits != 3'b000) & ~one_hot;
    assign busy     = (state_q != S_IDLE);
    // A latched but not yet issued command also protects the operands.
    assign locked   = busy | go_q;
    assign accept   = ctrl_wr & ~abort & ~locked & one_hot;
    assign drop     = locked & ((key_wr | non_wr | dat_wr | cfg_wr) |
                                (ctrl_wr & ~abort & (cmd_bits != 3'b000)));

    assign complete = (state_q == S_WAIT) & seen_low_q & core_ready & ~abort;
    assign tmo_hit  = (state_q == S_WAIT) & ~complete & ~abort &
                      (tmo_q == TMO_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (go_q) state_d = S_PULSE;
                S_PULSE: state_d = S_WAIT;
                S_WAIT:  if (complete | tmo_hit) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        core_init = 1'b0;
        core_next = 1'b0;
        core_done = 1'b0;
        if (state_q == S_PULSE) begin
            core_init = cmd_q[0];
            core_next = cmd_q[1];
            core_done = cmd_q[2];
        end
    end

    // ---------------- register next-state ----------------
    always_comb begin
        key_d      = key_q;
        nonce_d    = nonce_q;
        data_d     = data_q;
        encdec_d   = encdec_q;
        cmd_d      = accept ? cmd_bits : cmd_q;
        go_d       = go_q;
        seen_low_d = (state_q == S_WAIT) & (seen_low_q | ~core_ready);
        tmo_d      = (abort || state_q != S_WAIT) ? 16'd0 : tmo_q + 16'd1;
        err_d      = err_q;
        done_d     = done_q;
        blkcnt_d   = blkcnt_q;

        if (abort)                     go_d = 1'b0;
        else if (accept)               go_d = 1'b1;
        else if (state_q == S_IDLE)    go_d = 1'b0;

        if (!locked) begin
            if (key_wr) key_d[address[2:0]]   = write_data;
            if (non_wr) nonce_d[address[1:0]] = write_data;
            if (dat_wr) data_d[didx]          = write_data;
            if (cfg_wr) encdec_d              = write_data[0];
        end

        // Clears first so that a same-cycle set event wins.
        if (stat_wr & write_data[4]) done_d = 1'b0;
        if (stat_wr & write_data[5]) err_d  = 1'b0;
        if (complete) done_d = 1'b1;
        if (drop | tmo_hit | (ctrl_wr & ~abort & ~locked & multi))
            err_d = 1'b1;

        if (cnt_wr)                     blkcnt_d = 16'd0;
        else if (complete & cmd_q[1])   blkcnt_d = blkcnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q      <= '{default: '0};
            nonce_q    <= '{default: '0};
            data_q     <= '{default: '0};
            encdec_q   <= 1'b0;
            cmd_q      <= 3'b000;
            go_q       <= 1'b0;
            seen_low_q <= 1'b0;
            tmo_q      <= 16'd0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            blkcnt_q   <= 16'd0;
        end else begin
            key_q      <= key_d;
            nonce_q    <= nonce_d;
            data_q     <= data_d;
            encdec_q   <= encdec_d;
            cmd_q      <= cmd_d;
            go_q       <= go_d;
            seen_low_q <= seen_low_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            done_q     <= done_d;
            blkcnt_q   <= blkcnt_d;
        end
    end

`ifdef AEAD_BUS_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr & (address == 8'h0B)) irq_en_q <= write_data[0];
            irq_q <= irq_en_q & (done_q | err_q);
        end
    end

    assign irq = irq_q;
`endif

    // ---------------- operand / result packing ----------------
    for (genvar i = 0; i < 8; i++) begin : g_key
        assign core_key[255-32*i -: 32] = key_q[i];
    end

    assign core_nonce = {nonce_q[2], nonce_q[1], nonce_q[0]};

    for (genvar i = 0; i < DATA_WORDS; i++) begin : g_data
        assign core_data_in[DATA_WORDS*32-1-32*i -: 32] = data_q[i];
        assign dout_w[i] = core_data_out[DATA_WORDS*32-1-32*i -: 32];
    end

    for (genvar j = 0; j < 4; j++) begin : g_tag
        assign tag_w[j] = core_tag[127-32*j -: 32];
    end

    assign core_encdec = encdec_q;

    // ---------------- read path ----------------
    assign status = {22'd0, state_q, 2'd0, err_q, done_q, busy,
                     core_tag_ok, core_valid, core_ready};

    always_comb begin
        rmux = 32'd0;
        if (address == 8'h00)       rmux = 32'h63323070;
        else if (address == 8'h01)  rmux = 32'h31333035;
        else if (address == 8'h02)  rmux = 32'h302e3032;
        else if (address == 8'h09)  rmux = status;
        else if (address == 8'h0A)  rmux = {31'd0, encdec_q};
`ifdef AEAD_BUS_IRQ_EN
        else if (address == 8'h0B)  rmux = {31'd0, irq_en_q};
`endif
        else if (address == 8'h0C)  rmux = {16'd0, blkcnt_q};
        else if (address[7:3] == 5'b00010)
            rmux = key_q[address[2:0]];
        else if (address >= 8'h20 && address <= 8'h22)
            rmux = nonce_q[address[1:0]];
        else if (address >= 8'h30 && doff < DW8)
            rmux = dout_w[didx];
        else if (address >= 8'h40 && address <= 8'h43)
            rmux = tag_w[address[1:0]];
    end

    // Capture at the sampling edge, present one edge later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q    <= 1'b0;
            rdata_q <= 32'd0;
            rdout_q <= 32'd0;
        end else begin
            rd_q <= rd;
            if (rd)   rdata_q <= rmux;
            if (rd_q) rdout_q <= rdata_q;
        end
    end

    assign read_data = rdout_q;

endmodule

// File: tb/tb_aead_bus_seq.sv
// tb_aead_bus_seq: directed self-checking bench for aead_bus_seq.
// Main instance uses default parameters; a second one has CORE_TIMEOUT=8.
module tb_aead_bus_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         cs, t_cs, we;
    logic [7:0]   address;
    logic [31:0]  write_data;

    logic [31:0]  m_rd, t_rd;
    logic         core_init, core_next, core_done, core_encdec;
    logic [255:0] core_key;
    logic [95:0]  core_nonce;
    logic [511:0] core_data_in, core_data_out;
    logic [127:0] core_tag;
    logic         core_ready, tb_ready, m_ready, mdrive;
`ifdef AEAD_BUS_IRQ_EN
    logic         irq, t_irq;
`endif

    logic         t_init, t_next, t_done, t_encdec;
    logic [255:0] t_key;
    logic [95:0]  t_nonce;
    logic [63:0]  t_din;

    int checks = 0;
    int errors = 0;
    int nx_cnt = 0, in_cnt = 0, dn_cnt = 0, t_nx_cnt = 0;
    int mcnt;
    logic [31:0] trace [32];
    logic [31:0] r;

    assign core_ready = mdrive ? m_ready : tb_ready;

    aead_bus_seq u_dut (
`ifdef AEAD_BUS_IRQ_EN
        .irq(irq),
`endif
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we),
        .address(address), .write_data(write_data), .read_data(m_rd),
        .core_init(core_init), .core_next(core_next),
        .core_done(core_done), .core_encdec(core_encdec),
        .core_key(core_key), .core_nonce(core_nonce),
        .core_data_in(core_data_in), .core_ready(core_ready),
        .core_valid(1'b0), .core_tag_ok(1'b0),
        .core_data_out(core_data_out), .core_tag(core_tag)
    );

    aead_bus_seq #(.DATA_WORDS(2), .CORE_TIMEOUT(8)) u_to (
`ifdef AEAD_BUS_IRQ_EN
        .irq(t_irq),
`endif
        .clk(clk), .reset_n(reset_n), .cs(t_cs), .we(we),
        .address(address), .write_data(write_data), .read_data(t_rd),
        .core_init(t_init), .core_next(t_next),
        .core_done(t_done), .core_encdec(t_encdec),
        .core_key(t_key), .core_nonce(t_nonce),
        .core_data_in(t_din), .core_ready(1'b1),
        .core_valid(1'b0), .core_tag_ok(1'b0),
        .core_data_out(64'h0), .core_tag(128'h0)
    );

    // Core model: ready drops one cycle after a strobe, returns 10 later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ready <= 1'b1;
            mcnt    <= 0;
        end else if (core_next || core_init) begin
            mcnt <= 1;
        end else if (mcnt == 1) begin
            m_ready <= 1'b0;
            mcnt    <= 2;
        end else if (mcnt >= 2 && mcnt < 11) begin
            mcnt <= mcnt + 1;
        end else if (mcnt == 11) begin
            m_ready <= 1'b1;
            mcnt    <= 0;
        end
    end

    always @(posedge clk) begin
        if (core_next) nx_cnt   <= nx_cnt + 1;
        if (core_init) in_cnt   <= in_cnt + 1;
        if (core_done) dn_cnt   <= dn_cnt + 1;
        if (t_next)    t_nx_cnt <= t_nx_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input bit t, input logic [7:0] a,
                          input logic [31:0] d);
        @(negedge clk);
        if (t) t_cs = 1'b1; else cs = 1'b1;
        we = 1'b1; address = a; write_data = d;
        @(negedge clk);
        cs = 1'b0; t_cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input bit t, input logic [7:0] a,
                          output logic [31:0] d);
        @(negedge clk);
        if (t) t_cs = 1'b1; else cs = 1'b1;
        we = 1'b0; address = a;
        @(negedge clk);
        cs = 1'b0; t_cs = 1'b0;
        @(negedge clk);
        d = t ? t_rd : m_rd;
    endtask

    // CTRL write at edge N, then STATUS read every cycle.
    // trace[j] (j>=2) holds STATUS as it stood after edge N+j-2.
    task automatic cmd_trace(input bit t, input logic [31:0] ctrl,
                             input int n);
        @(negedge clk);
        if (t) t_cs = 1'b1; else cs = 1'b1;
        we = 1'b1; address = 8'h08; write_data = ctrl;
        @(negedge clk);
        we = 1'b0; address = 8'h09;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            trace[j] = t ? t_rd : m_rd;
        end
        cs = 1'b0; t_cs = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; cs = 1'b0; t_cs = 1'b0; we = 1'b0;
        address = 8'h00; write_data = 32'h0;
        tb_ready = 1'b0; mdrive = 1'b0;
        core_tag = 128'h11111111_22222222_33333333_44444444;
        for (int i = 0; i < 16; i++)
            core_data_out[511-32*i -: 32] = 32'hA5A50000 + i;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_rdata", m_rd, 32'h0);
        chk("rst_outs", {28'h0, core_init, core_next, core_done, core_encdec},
            32'h0);
        bus_rd(0, 8'h00, r); chk("const0", r, 32'h63323070);
        bus_rd(0, 8'h01, r); chk("const1", r, 32'h31333035);
        bus_rd(0, 8'h02, r); chk("const2", r, 32'h302e3032);
        bus_rd(0, 8'h09, r); chk("rst_status", r, 32'h0);
        bus_rd(0, 8'h0C, r); chk("rst_blkcnt", r, 32'h0);
        bus_rd(0, 8'h08, r); chk("ctrl_rd0", r, 32'h0);
        bus_rd(0, 8'h50, r); chk("unmapped", r, 32'h0);
`ifndef AEAD_BUS_IRQ_EN
        bus_rd(0, 8'h0B, r); chk("irq_reg_absent", r, 32'h0);
`endif

        // operand registers
        bus_wr(0, 8'h0A, 32'h1);
        chk("encdec", {31'h0, core_encdec}, 32'h1);
        bus_rd(0, 8'h0A, r); chk("config_rd", r, 32'h1);
        bus_wr(0, 8'h10, 32'h11112222);
        bus_wr(0, 8'h17, 32'h77778888);
        chk("key_w0", core_key[255:224], 32'h11112222);
        chk("key_w7", core_key[31:0], 32'h77778888);
        bus_rd(0, 8'h17, r); chk("key_rd7", r, 32'h77778888);
        bus_wr(0, 8'h20, 32'hAAAA0000);
        bus_wr(0, 8'h22, 32'hCCCC2222);
        chk("nonce_n2", core_nonce[95:64], 32'hCCCC2222);
        chk("nonce_n0", core_nonce[31:0], 32'hAAAA0000);
        bus_wr(0, 8'h30, 32'h12345678);
        chk("data_in0", core_data_in[511:480], 32'h12345678);
        bus_rd(0, 8'h33, r); chk("data_out3", r, 32'hA5A50003);
        bus_rd(0, 8'h40, r); chk("tag0", r, 32'h11111111);
        bus_rd(0, 8'h43, r); chk("tag3", r, 32'h44444444);

        // next command against the core model
        mdrive = 1'b1;
        cmd_trace(0, 32'h2, 16);
        chk("nx_after_wr", trace[2] & 32'h30B, 32'h001);
        chk("nx_pulse_st", trace[3] & 32'h308, 32'h108);
        chk("nx_wait_st", trace[4] & 32'h308, 32'h208);
        chk("nx_busy_13", trace[15] & 32'h318, 32'h208);
        chk("nx_done_14", trace[16], 32'h011);
        chk("nx_pulses", nx_cnt, 1);
        bus_rd(0, 8'h0C, r); chk("blkcnt_1", r, 32'h1);
        bus_wr(0, 8'h0C, 32'h1234);
        bus_rd(0, 8'h0C, r); chk("blkcnt_clr", r, 32'h0);

        // multi-bit command in IDLE
        bus_wr(0, 8'h09, 32'h10);
        mdrive = 1'b0; tb_ready = 1'b0;
        bus_wr(0, 8'h08, 32'h3);
        bus_rd(0, 8'h09, r); chk("multi_status", r, 32'h20);
        chk("multi_nostrobe", nx_cnt + in_cnt + dn_cnt, 1);
        bus_wr(0, 8'h09, 32'h20);
        bus_rd(0, 8'h09, r); chk("err_clear", r, 32'h0);

        // timeout instance: core never completes
        cmd_trace(1, 32'h2, 12);
        chk("to_wait_7", trace[11] & 32'h338, 32'h208);
        chk("to_idle_8", trace[12], 32'h021);
        chk("to_pulses", t_nx_cnt, 1);
        bus_rd(1, 8'h0C, r); chk("to_blkcnt", r, 32'h0);

        // protection while busy, then abort
        tb_ready = 1'b1;
        bus_wr(0, 8'h08, 32'h2);
        bus_wr(0, 8'h10, 32'hDEADBEEF);
        chk("key_protect", core_key[255:224], 32'h11112222);
        cmd_trace(0, 32'h8, 3);
        chk("abort_idle", trace[2], 32'h021);
        bus_rd(0, 8'h10, r); chk("key_rd_prot", r, 32'h11112222);

        // BLKCNT wrap
        bus_wr(0, 8'h09, 32'h30);
        @(negedge clk);
        force u_dut.blkcnt_q = 16'hFFFF;
        @(negedge clk);
        release u_dut.blkcnt_q;
        bus_rd(0, 8'h0C, r); chk("blkcnt_ffff", r, 32'hFFFF);
        mdrive = 1'b1;
        cmd_trace(0, 32'h2, 16);
        chk("wrap_done", trace[16], 32'h011);
        bus_rd(0, 8'h0C, r); chk("blkcnt_wrap", r, 32'h0);

`ifdef AEAD_BUS_IRQ_EN
        bus_wr(0, 8'h09, 32'h30);
        bus_wr(0, 8'h0B, 32'h1);
        bus_rd(0, 8'h0B, r); chk("irq_en_rd", r, 32'h1);
        chk("irq_idle", {31'h0, irq}, 32'h0);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; address = 8'h08; write_data = 32'h1;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
        repeat (14) @(negedge clk);
        chk("irq_at_done", {31'h0, irq}, 32'h0);
        @(negedge clk);
        chk("irq_rise", {31'h0, irq}, 32'h1);
        chk("init_pulses", in_cnt, 1);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; address = 8'h09; write_data = 32'h10;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
        chk("irq_hold", {31'h0, irq}, 32'h1);
        @(negedge clk);
        chk("irq_fall", {31'h0, irq}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aead_bus_seq.md
# aead_bus_seq

Register-mapped bus front end for the ChaCha20-Poly1305 AEAD core with a hardware command sequencer. It replaces bare strobe pass-through with an FSM that issues one-cycle core strobes, tracks completion and timeout, protects operands while busy, and counts completed blocks. It sits between the CPU-side 32-bit register bus and the core; the core attaches through the `core_*` ports.

## Interface
- `DATA_WORDS`, 16: number of 32-bit data words; legal range 1..16. Data window is 0x30..0x30+DATA_WORDS-1.
- `CORE_TIMEOUT`, 1023: maximum cycles spent in WAIT before the sequencer aborts. Legal range 2..65535.
- `clk` in 1: the block's single clock. All logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cs` in 1: bus select.
- `we` in 1: 1 = write, 0 = read.
- `address` in 8: word address.
- `write_data` in 32: write data.
- `read_data` out 32: registered read data.
- `core_init`, `core_next`, `core_done` out 1 each: one-cycle command strobes.
- `core_encdec` out 1: mode.
- `core_key` out 256: key, with word 0 in the MSBs.
- `core_nonce` out 96: nonce as {n2,n1,n0}.
- `core_data_in` out DATA_WORDS*32: data, with word 0 in the MSBs.
- `core_ready`, `core_valid`, `core_tag_ok` in 1 each: core status.
- `core_data_out` in DATA_WORDS*32: core output data.
- `core_tag` in 128: tag.
- `irq` out 1: interrupt. Present only with the IRQ feature.

## Operation
Address map:
- 0x00 / 0x01 / 0x02: constants 0x63323070, 0x31333035, 0x302e3032.
- 0x08 CTRL (write-only): bit0 init, bit1 next, bit2 done, bit3 abort. Reads return 0.
- 0x09 STATUS:
  - bits {9:8 fsm_state, 5 error, 4 done_sticky, 3 busy, 2 tag_ok, 1 valid, 0 ready}.
  - Writing 1 to bit 4 or bit 5 clears that bit.
- 0x0A CONFIG: bit0 encdec.
- 0x0C BLKCNT: 16-bit count of completed `next` commands. Wraps 0xFFFF to 0. Any write clears it.
- 0x10..0x17 key, 0x20..0x22 nonce, 0x30.. data. All are read/write. A data read returns the `core_data_out` word, not the written word.
- 0x40..0x43: tag words, tag[127:96] first.
- All other addresses read 0; writes to them are ignored.

FSM states:
- IDLE (0):
  - A CTRL write with exactly one of bits 0..2 set latches the command and moves to PULSE.
  - A CTRL write with zero or more than one of bits 0..2 set: no action. If more than one bit is set, error is set.
- PULSE (1): assert the latched strobe for exactly one cycle, then move to WAIT.
- WAIT (2):
  - Complete once `core_ready` has been sampled low at least once and is then sampled high.
  - On completion: go to IDLE, set done_sticky. If the command was `next`, increment BLKCNT.
  - On reaching CORE_TIMEOUT WAIT cycles: go to IDLE, set error. done_sticky is not set.
- busy = (state != IDLE).
- Abort (CTRL bit3) in any state: go to IDLE the next cycle, clear the timeout counter, and issue no strobe. Abort takes priority over command bits in the same write.
- While busy:
  - Writes to key, nonce, data, CONFIG or command bits are dropped and set error.
  - Abort and STATUS clear writes are always accepted.
- A single STATUS write whose clear bit coincides with a same-cycle set event: the set wins.

## Timing
- Reset values: `read_data` = 0, all strobes = 0, `core_encdec` = 0, `irq` = 0. All registers, BLKCNT and error/done flags are 0. State is IDLE.
- Write: takes effect at the rising edge where `cs & we` is sampled.
- Read: `cs & !we` is sampled at edge N; `read_data` is valid after edge N+1 and held until the next read. This is one cycle of latency, fully synchronous.
- CTRL command written at edge N:
  - State is PULSE after edge N+1, so the strobe is high during cycle N+1..N+2.
  - State is WAIT from edge N+2.
  - Minimum command-to-done_sticky time is 4 edges.
- Asserting `reset_n` mid-operation forces reset values immediately; no strobe is emitted afterwards.

## Configuration
- `AEAD_BUS_IRQ_EN` defined:
  - Adds register 0x0B IRQ with bit0 enable (read/write).
  - `irq` is registered and equals enable & (done_sticky | error); it updates the cycle after either flag changes.
- Macro undefined:
  - The `irq` port and register 0x0B do not exist; 0x0B reads 0.
  - All other behaviour is identical.

## Test plan
- Reset then read 0x00..0x02 → 0x63323070, 0x31333035, 0x302e3032. STATUS reads 0x0 with core_ready=0.
- Write key/nonce, CTRL=0x2. Core model drops ready 1 cycle after the strobe and raises it 10 cycles later. Expect: one `core_next` pulse of exactly 1 cycle, STATUS bit4=1, BLKCNT=1, busy low 4+10 edges after the write.
- Write CTRL=0x3 in IDLE → no strobe, STATUS=0x20. Write 1 to bit5 → STATUS=0x0.
- Issue next with a core that never completes, CORE_TIMEOUT=8 → IDLE after 8 WAIT cycles, error=1, done_sticky=0, BLKCNT unchanged.
- While busy, write key word 0x10=0xDEADBEEF, then CTRL=0x8 → key unchanged, error=1, IDLE next cycle. BLKCNT=0xFFFF plus one completed next → 0x0000.
- With `AEAD_BUS_IRQ_EN`: IRQ=1, complete an init → `irq` rises 1 cycle after done_sticky; clearing bit4 drops `irq` 1 cycle later.
